// File: rtl/result_ascii_tx.sv
// Converts a binary result to decimal ASCII (double-dabble) and streams it
// one character per beat, MSB digit first, newline-terminated; "ERR\n" on error.
module result_ascii_tx #(
   parameter int NUM_PATHS_DW = 64,
   parameter int NUM_DIGITS   = 20
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_PATHS_DW-1:0] i_result,
   input  logic                    i_result_vld,
   input  logic                    i_error,
   output logic                    o_ready,
   output logic                    o_vld,
   output logic [7:0]              o_char,
   input  logic                    i_stall,
   output logic                    o_busy,
   output logic                    o_drop
);

   localparam int CW = $clog2(NUM_PATHS_DW + 1);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = 4 * NUM_DIGITS;

   typedef enum logic [2:0] {
      IDLE, CONVERT, FIND, EMIT, NEWLINE, ERRMSG
   } state_t;

   state_t                  state_q, state_d;
   logic [NUM_PATHS_DW-1:0] shift_q, shift_d;
   logic [BW-1:0]           bcd_q, bcd_d, bcd_adj;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d, msd;
   logic [1:0]              eidx_q, eidx_d;
   logic                    drop_q, drop_d;
   logic [3:0]              digit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         eidx_q  <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         eidx_q  <= eidx_d;
         drop_q  <= drop_d;
      end
   end

   // Per-digit add-3 correction; digits are independent, no carry between them.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // Highest nonzero digit; all-zero leaves index 0 so a lone "0" is emitted.
   always_comb begin
      msd = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) msd = IW'(i);
      end
   end

   always_comb begin
      digit = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IW'(i)) digit = bcd_q[4*i +: 4];
      end
   end

   assign o_busy  = (state_q != IDLE);
   assign o_ready = ~o_busy;
   assign o_drop  = drop_q;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      eidx_d  = eidx_q;
      drop_d  = drop_q | (i_result_vld & (state_q != IDLE));
      o_vld   = 1'b0;
      o_char  = 8'h00;
      case (state_q)
         IDLE: begin
            if (i_result_vld) begin
               if (i_error) begin
                  eidx_d  = 2'd0;
                  state_d = ERRMSG;
               end else begin
                  shift_d = i_result;
                  bcd_d   = '0;
                  cnt_d   = '0;
                  state_d = CONVERT;
               end
            end
         end
         CONVERT: begin
            {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(NUM_PATHS_DW - 1)) state_d = FIND;
         end
         FIND: begin
            idx_d   = msd;
            state_d = EMIT;
         end
         EMIT: begin
            o_vld  = 1'b1;
            o_char = 8'h30 + {4'h0, digit};
            if (!i_stall) begin
               if (idx_q == '0) state_d = NEWLINE;
               else             idx_d   = idx_q - 1'b1;
            end
         end
         NEWLINE: begin
            o_vld  = 1'b1;
            o_char = 8'h0A;
            if (!i_stall) state_d = IDLE;
         end
         ERRMSG: begin
            o_vld = 1'b1;
            case (eidx_q)
               2'd0:    o_char = 8'h45;
               2'd1,
               2'd2:    o_char = 8'h52;
               default: o_char = 8'h0A;
            endcase
            if (!i_stall) begin
               if (eidx_q == 2'd3) state_d = IDLE;
               else                eidx_d  = eidx_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
